inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/inst_fetch.sv | 98 +++++++++
 tb/tb_inst_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch definitions: state encoding, default widths and reset PC.
// Imported by the fetch unit and by the instruction-memory side.
package inst_fetch_pkg;

    localparam int unsigned INST_WIDTH_DEF      = 32;
    localparam int unsigned INST_ADDR_WIDTH_DEF = 7;
    localparam logic [31:0] RESET_PC_DEF        = 32'h0000_0000;
    localparam int unsigned QUEUE_DEPTH         = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_e;

    // Instructions are word aligned; the low two PC bits carry no meaning.
    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched {instruction, pc} pairs.
// Synchronous flush empties it; count reports occupancy.
module fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [QUEUE_DEPTH];
    logic [WIDTH-1:0] mem_d [QUEUE_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    // Pointer, occupancy and storage update; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == 2'd0);
    assign count     = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues word reads, tags responses with their PC,
// buffers up to two outstanding instructions and hands them to decode.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned INST_WIDTH      = INST_WIDTH_DEF,
    parameter int unsigned INST_ADDR_WIDTH = INST_ADDR_WIDTH_DEF,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_en,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       mem_request,
    output logic [INST_ADDR_WIDTH-1:0] mem_addr,
    input  logic                       mem_valid,
    input  logic [INST_WIDTH-1:0]      mem_inst,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [INST_WIDTH-1:0]      inst,
    output logic [31:0]                inst_pc
);

    localparam int unsigned QW = INST_WIDTH + 32;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  tag_q, tag_d;

    logic          q_push;
    logic          q_pop;
    logic          q_empty;
    logic [1:0]    q_count;
    logic [QW-1:0] q_wdata;
    logic [QW-1:0] q_rdata;
    logic [2:0]    outstanding;
    logic          req;

    // Handshake and issue gating; a redirect cycle blocks both delivery and issue.
    always_comb begin
        inst_valid  = !q_empty && !redirect;
        q_pop       = inst_valid && inst_ready;
        outstanding = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, q_pop};
        req         = (state_q == RUN) && !redirect && (outstanding < 3'd2);
        q_push      = mem_valid && inflight_q && !redirect;
        q_wdata     = {mem_inst, tag_q};
    end

    // Next state, request PC and in-flight tag.
    always_comb begin
        state_d    = redirect ? REDIRECT : (fetch_en ? RUN : IDLE);
        pc_d       = pc_q;
        inflight_d = req;
        tag_d      = req ? pc_q : tag_q;
        unique case (1'b1)
            redirect: pc_d = word_align(redirect_pc);
            req:      pc_d = pc_q + 32'd4;
            default:  pc_d = pc_q;
        endcase
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= word_align(RESET_PC);
            inflight_q <= 1'b0;
            tag_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    fetch_queue #(
        .WIDTH(QW)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .push     (q_push),
        .push_data(q_wdata),
        .pop      (q_pop),
        .head_data(q_rdata),
        .empty    (q_empty),
        .count    (q_count)
    );

    assign mem_request = req;
    assign mem_addr    = pc_q[INST_ADDR_WIDTH+1:2];
    assign inst        = q_rdata[QW-1:32];
    assign inst_pc     = q_rdata[31:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: latency-1 memory model, PC scoreboard,
// a cycle table for start-up/back-pressure and hand sequences for corners.
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_request;
    logic [6:0]  mem_addr;
    logic        mem_valid;
    logic [31:0] mem_inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        spur;
    int          errors;
    int          checks;
    logic [31:0] sb[$];
    logic [31:0] exp_pc;

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        ereq;
        logic [6:0]  eaddr;
        logic        evld;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[14];

    inst_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .mem_request(mem_request),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_inst   (mem_inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [6:0] a);
        return {16'hC0DE, 9'd0, a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory: answers a request seen in one cycle during the next cycle.
    // spur injects a response with no request one cycle later.
    initial begin
        logic       req_s;
        logic [6:0] addr_s;
        mem_valid = 1'b0;
        mem_inst  = 32'd0;
        forever begin
            @(negedge clk);
            req_s  = mem_request || spur;
            addr_s = mem_addr;
            @(posedge clk);
            #1;
            mem_valid = req_s;
            mem_inst  = mdata(addr_s);
        end
    end

    // Scoreboard: every issued request must be delivered in order unless
    // a redirect or reset discards it.
    initial begin
        logic [31:0] e;
        exp_pc = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                exp_pc = 32'd0;
            end else if (redirect) begin
                sb.delete();
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (inst_valid && inst_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", inst_pc, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_pc", inst_pc, e);
                        chk("sb_inst", inst, mdata(e[8:2]));
                    end
                end
                if (mem_request) begin
                    chk("sb_addr", {25'd0, mem_addr}, {25'd0, exp_pc[8:2]});
                    sb.push_back(exp_pc);
                    exp_pc = exp_pc + 32'd4;
                    chk("sb_outstanding", {31'd0, sb.size() <= 2}, 32'd1);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic r, input logic fe,
                       input logic rdy, input logic rd,
                       input logic [31:0] rpc, input logic sp,
                       input logic ereq, input logic [6:0] eaddr,
                       input logic evld, input logic [31:0] epc);
        @(posedge clk);
        #1;
        rst_n       = r;
        fetch_en    = fe;
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        spur        = sp;
        @(negedge clk);
        chk({nm, "_req"}, {31'd0, mem_request}, {31'd0, ereq});
        chk({nm, "_addr"}, {25'd0, mem_addr}, {25'd0, eaddr});
        chk({nm, "_vld"}, {31'd0, inst_valid}, {31'd0, evld});
        if (evld) chk({nm, "_pc"}, inst_pc, epc);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b1;
        fetch_en    = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        spur        = 1'b0;

        // Start-up at 1/cycle, then 5 cycles of back-pressure and release.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 7'd0, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 7'd1, 1'b0, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 7'd2, 1'b1, 32'h00};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 7'd3, 1'b1, 32'h04};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 7'd4, 1'b1, 32'h08};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 7'd5, 1'b1, 32'h0C};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 7'd5, 1'b1, 32'h0C};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 7'd5, 1'b1, 32'h0C};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 7'd5, 1'b1, 32'h0C};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 7'd5, 1'b1, 32'h0C};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 7'd5, 1'b1, 32'h0C};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 7'd6, 1'b1, 32'h10};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 7'd7, 1'b1, 32'h14};

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, mem_request}, 32'd0);
        chk("rst_vld", {31'd0, inst_valid}, 32'd0);
        chk("rst_addr", {25'd0, mem_addr}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cyc($sformatf("vec%0d", i), 1'b1, tbl[i].fe, tbl[i].rdy,
                1'b0, 32'd0, 1'b0, tbl[i].ereq, tbl[i].eaddr,
                tbl[i].evld, tbl[i].epc);
        end

        // Redirect to 0x40 with a full queue.
        cyc("fill",  1, 1, 0, 0, 32'h0,  0, 0, 7'h08, 1, 32'h18);
        cyc("rd40",  1, 1, 1, 1, 32'h40, 0, 0, 7'h08, 0, 32'h0);
        cyc("rd40a", 1, 1, 1, 0, 32'h0,  0, 0, 7'h10, 0, 32'h0);
        cyc("rd40b", 1, 1, 1, 0, 32'h0,  0, 1, 7'h10, 0, 32'h0);
        cyc("rd40c", 1, 1, 1, 0, 32'h0,  0, 1, 7'h11, 0, 32'h0);
        cyc("rd40d", 1, 1, 1, 0, 32'h0,  0, 1, 7'h12, 1, 32'h40);

        // Redirect with inst_ready high and an unaligned target.
        cyc("rd43",  1, 1, 1, 1, 32'h43, 0, 0, 7'h13, 0, 32'h0);
        cyc("rd43a", 1, 1, 1, 0, 32'h0,  0, 0, 7'h10, 0, 32'h0);
        cyc("rd43b", 1, 1, 1, 0, 32'h0,  0, 1, 7'h10, 0, 32'h0);
        cyc("rd43c", 1, 1, 1, 0, 32'h0,  0, 1, 7'h11, 0, 32'h0);
        cyc("rd43d", 1, 1, 1, 0, 32'h0,  0, 1, 7'h12, 1, 32'h40);

        // Back-to-back redirects, then the word-address wrap at 0x1FC.
        cyc("dbl1",  1, 1, 1, 1, 32'h100, 0, 0, 7'h13, 0, 32'h0);
        cyc("dbl2",  1, 1, 1, 1, 32'h1FC, 0, 0, 7'h40, 0, 32'h0);
        cyc("dbl3",  1, 1, 1, 0, 32'h0,   0, 0, 7'h7F, 0, 32'h0);
        cyc("wrap1", 1, 1, 1, 0, 32'h0,   0, 1, 7'h7F, 0, 32'h0);
        cyc("wrap2", 1, 1, 1, 0, 32'h0,   0, 1, 7'h00, 0, 32'h0);
        cyc("wrap3", 1, 1, 1, 0, 32'h0,   0, 1, 7'h01, 1, 32'h1FC);
        cyc("wrap4", 1, 1, 1, 0, 32'h0,   0, 1, 7'h02, 1, 32'h200);

        // fetch_en falls: issue stops, outstanding work still drains.
        cyc("fe0a", 1, 0, 1, 0, 32'h0, 0, 1, 7'h03, 1, 32'h204);
        cyc("fe0b", 1, 0, 1, 0, 32'h0, 0, 0, 7'h04, 1, 32'h208);
        cyc("fe0c", 1, 0, 1, 0, 32'h0, 0, 0, 7'h04, 1, 32'h20C);
        cyc("fe0d", 1, 0, 1, 0, 32'h0, 0, 0, 7'h04, 0, 32'h0);

        // Spurious response while idle must not be queued.
        cyc("spur1", 1, 0, 1, 0, 32'h0, 1, 0, 7'h04, 0, 32'h0);
        cyc("spur2", 1, 0, 1, 0, 32'h0, 0, 0, 7'h04, 0, 32'h0);
        cyc("spur3", 1, 0, 1, 0, 32'h0, 0, 0, 7'h04, 0, 32'h0);

        // Resume, then reset mid-stream with a stale response at release.
        cyc("res1", 1, 1, 1, 0, 32'h0, 0, 0, 7'h04, 0, 32'h0);
        cyc("res2", 1, 1, 1, 0, 32'h0, 0, 1, 7'h04, 0, 32'h0);
        cyc("res3", 1, 1, 1, 0, 32'h0, 0, 1, 7'h05, 0, 32'h0);
        cyc("res4", 1, 1, 1, 0, 32'h0, 0, 1, 7'h06, 1, 32'h210);
        cyc("mrst1", 0, 1, 1, 0, 32'h0, 0, 0, 7'h00, 0, 32'h0);
        cyc("mrst2", 0, 1, 1, 0, 32'h0, 1, 0, 7'h00, 0, 32'h0);
        cyc("rel1",  1, 1, 1, 0, 32'h0, 0, 0, 7'h00, 0, 32'h0);
        cyc("rel2",  1, 1, 1, 0, 32'h0, 0, 1, 7'h00, 0, 32'h0);
        cyc("rel3",  1, 1, 1, 0, 32'h0, 0, 1, 7'h01, 0, 32'h0);
        cyc("rel4",  1, 1, 1, 0, 32'h0, 0, 1, 7'h02, 1, 32'h0);
        cyc("drn1",  1, 0, 1, 0, 32'h0, 0, 1, 7'h03, 1, 32'h4);
        cyc("drn2",  1, 0, 1, 0, 32'h0, 0, 0, 7'h04, 1, 32'h8);
        cyc("drn3",  1, 0, 1, 0, 32'h0, 0, 0, 7'h04, 1, 32'hC);
        cyc("drn4",  1, 0, 1, 0, 32'h0, 0, 0, 7'h04, 0, 32'h0);

        @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
